// File: rtl/command_decoder.sv
// Frame parser: assembles SYNC/OPCODE/SA/EA/CHK frames from the UART receiver,
// validates them and hands opcode plus address range to the processor via valid/ack.
module command_decoder #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    input  logic        cmd_ack,
    output logic [7:0]  command,
    output logic [15:0] start_address,
    output logic [15:0] end_address,
    output logic        cmd_valid,
    output logic        frame_error,
    output logic [1:0]  error_code
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_CHECKSUM = 2'd0;
    localparam logic [1:0] ERR_OPCODE   = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_SYNC,
        S_OPCODE,
        S_SA_HI,
        S_SA_LO,
        S_EA_HI,
        S_EA_LO,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic             rx_done_q, rx_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       op_q, op_d;
    logic [15:0]      sa_q, sa_d;
    logic [15:0]      ea_q, ea_d;
    logic [7:0]       command_q, command_d;
    logic [15:0]      start_address_q, start_address_d;
    logic [15:0]      end_address_q, end_address_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             frame_error_q, frame_error_d;
    logic [1:0]       error_code_q, error_code_d;

    logic             byte_ev;
    logic             in_frame;
    logic [7:0]       chk_calc;

    assign byte_ev  = rx_done & ~rx_done_q;
    assign in_frame = (state_q != S_SYNC) && (state_q != S_HOLD);
    assign chk_calc = op_q ^ sa_q[15:8] ^ sa_q[7:0] ^ ea_q[15:8] ^ ea_q[7:0];

    always_comb begin
        state_d         = state_q;
        rx_done_d       = rx_done;
        cnt_d           = cnt_q;
        op_d            = op_q;
        sa_d            = sa_q;
        ea_d            = ea_q;
        command_d       = command_q;
        start_address_d = start_address_q;
        end_address_d   = end_address_q;
        cmd_valid_d     = cmd_valid_q;
        frame_error_d   = 1'b0;
        error_code_d    = error_code_q;

        if (!in_frame) begin
            cnt_d = '0;
        end else if (byte_ev) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Inter-byte gap exhausted; a byte arriving on this same edge would have won above.
            cnt_d         = '0;
            frame_error_d = 1'b1;
            error_code_d  = ERR_TIMEOUT;
            state_d       = S_SYNC;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_SYNC: begin
                if (byte_ev && rx_byte == SYNC_BYTE) state_d = S_OPCODE;
            end
            S_OPCODE: if (byte_ev) begin
                op_d    = rx_byte;
                state_d = S_SA_HI;
            end
            S_SA_HI: if (byte_ev) begin
                sa_d[15:8] = rx_byte;
                state_d    = S_SA_LO;
            end
            S_SA_LO: if (byte_ev) begin
                sa_d[7:0] = rx_byte;
                state_d   = S_EA_HI;
            end
            S_EA_HI: if (byte_ev) begin
                ea_d[15:8] = rx_byte;
                state_d    = S_EA_LO;
            end
            S_EA_LO: if (byte_ev) begin
                ea_d[7:0] = rx_byte;
                state_d   = S_CHECK;
            end
            S_CHECK: if (byte_ev) begin
                state_d = S_SYNC;
                if (rx_byte != chk_calc) begin
                    frame_error_d = 1'b1;
                    error_code_d  = ERR_CHECKSUM;
                end else if (op_q > 8'h01) begin
                    frame_error_d = 1'b1;
                    error_code_d  = ERR_OPCODE;
                end else if (sa_q > ea_q) begin
                    frame_error_d = 1'b1;
                    error_code_d  = ERR_RANGE;
                end else begin
                    command_d       = op_q;
                    start_address_d = sa_q;
                    end_address_d   = ea_q;
                    cmd_valid_d     = 1'b1;
                    state_d         = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cmd_ack) begin
                    cmd_valid_d = 1'b0;
                    command_d   = 8'hFF;
                    state_d     = S_SYNC;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_SYNC;
            rx_done_q       <= 1'b1;
            cnt_q           <= '0;
            op_q            <= '0;
            sa_q            <= '0;
            ea_q            <= '0;
            command_q       <= 8'hFF;
            start_address_q <= '0;
            end_address_q   <= '0;
            cmd_valid_q     <= 1'b0;
            frame_error_q   <= 1'b0;
            error_code_q    <= '0;
        end else begin
            state_q         <= state_d;
            rx_done_q       <= rx_done_d;
            cnt_q           <= cnt_d;
            op_q            <= op_d;
            sa_q            <= sa_d;
            ea_q            <= ea_d;
            command_q       <= command_d;
            start_address_q <= start_address_d;
            end_address_q   <= end_address_d;
            cmd_valid_q     <= cmd_valid_d;
            frame_error_q   <= frame_error_d;
            error_code_q    <= error_code_d;
        end
    end

    assign command       = command_q;
    assign start_address = start_address_q;
    assign end_address   = end_address_q;
    assign cmd_valid     = cmd_valid_q;
    assign frame_error   = frame_error_q;
    assign error_code    = error_code_q;

endmodule

// File: doc/command_decoder.md
# command_decoder

Frame parser between the UART receiver and the memory-management processor. Assembles bytes from the UART receiver into a 7-byte command frame, validates it, and presents opcode plus start/end BRAM addresses to the processor with a valid/ack handshake. Between commands it drives the no-op opcode 8'hFF, so the processor idles in its command-processing state.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles allowed between consecutive bytes inside a frame

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- rx_byte  in  8  byte from the UART receiver; stable while rx_done is high
- rx_done  in  1  UART receiver byte-ready level; each rising edge is one new byte
- cmd_ack  in  1  processor has taken the command; sampled only while cmd_valid=1
- command  out  8  opcode: 8'h00 read, 8'h01 write, 8'hFF no-op/idle
- start_address  out  16  first BRAM address of the transfer
- end_address  out  16  last BRAM address, inclusive
- cmd_valid  out  1  command and addresses are valid and held stable
- frame_error  out  1  one-cycle pulse when a frame is rejected
- error_code  out  2  cause of the last rejection: 0 checksum, 1 opcode, 2 range, 3 timeout

## Operation
- Frame layout, in order: SYNC, OPCODE, SA_HI, SA_LO, EA_HI, EA_LO, CHK.
- CHK = XOR of OPCODE, SA_HI, SA_LO, EA_HI and EA_LO.
- Byte event: rx_done=1 and rx_done_q=0, where rx_done_q is rx_done registered.
- States: S_SYNC, S_OPCODE, S_SA_HI, S_SA_LO, S_EA_HI, S_EA_LO, S_CHECK, S_HOLD.
- S_SYNC: on a byte event with rx_byte==SYNC_BYTE, go to S_OPCODE. Any other byte is discarded silently, with no error.
- S_OPCODE through S_EA_LO: each byte event latches the byte into an internal shadow register and advances one state. Outputs are not touched.
- S_CHECK, on the byte event, checks in this priority order:
  - checksum mismatch -> error 0
  - opcode not 00/01 -> error 1
  - start > end (unsigned 16-bit compare) -> error 2
- S_CHECK on any failure: pulse frame_error, load error_code, go to S_SYNC. Outputs stay unchanged.
- S_CHECK on pass: load command, start_address and end_address from the shadows, set cmd_valid=1, go to S_HOLD.
- S_HOLD: outputs held stable; byte events are ignored and dropped. When cmd_ack=1, next cycle: cmd_valid=0, command=8'hFF, go to S_SYNC. start_address and end_address keep their values.
- Timeout: an inter-byte counter clears on every byte event and in S_SYNC/S_HOLD, and increments in S_OPCODE..S_CHECK. When it reaches TIMEOUT_CYCLES-1: pulse frame_error, set error_code=3, clear the counter, go to S_SYNC. If a byte event occurs in the same cycle, the byte event wins and the counter clears.
- error_code holds its value until the next rejection.

## Timing
- Reset values: command=8'hFF, start_address=0, end_address=0, cmd_valid=0, frame_error=0, error_code=0, state S_SYNC, counter 0, rx_done_q=1.
  - rx_done_q=1 means an rx_done that is already high at reset release is not counted as a byte.
- Latency: a CHK byte event sampled at edge N gives cmd_valid=1 (or the frame_error pulse) visible after edge N, i.e. in cycle N+1.
- cmd_ack sampled at edge M while in S_HOLD gives cmd_valid=0 after edge M. cmd_ack is ignored when cmd_valid=0.
- At most one byte is consumed per rx_done high period. A level held high for many cycles counts once.
- rst during any state, including S_HOLD, returns every output to its reset value at the next edge and discards any partial frame.

## Test plan
- Good read frame A5 00 00 10 00 1F 0F -> command=00, start=0x0010, end=0x001F, cmd_valid=1 one cycle after the CHK rising edge; cmd_ack pulse -> cmd_valid=0, command=FF.
- Good write frame A5 01 12 34 12 34 01 with cmd_ack held low for 500 cycles and extra bytes sent meanwhile -> outputs stable, extra bytes ignored; frame accepted after ack.
- Bad checksum A5 01 00 00 00 05 00 -> frame_error single pulse, error_code=0, cmd_valid stays 0. Next correct frame is accepted.
- Opcode 02 with valid CHK -> error_code=1. Start 0x0020 > end 0x0010 with valid CHK -> error_code=2.
- Leading garbage 11 22 A5 ... (valid frame) -> garbage dropped with no error; frame accepted. rx_done held high 1000 cycles counts as one byte.
- TIMEOUT_CYCLES=100: send A5 01, then idle 100 cycles -> frame_error at cycle 99 after the last byte, error_code=3, then re-sync on the next A5. Assert rst mid-frame -> all outputs at reset values next cycle.
